// File: rtl/vdp_port_if_pkg.sv
// Shared constants and types for the VDP CPU port responder.
// Holds port selects, FSM states, status bit positions, sprite-none code.
package vdp_pkg;

   localparam logic DATA_PORT = 1'b0;
   localparam logic CTRL_PORT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      WR_WAIT,
      RD_WAIT
   } state_t;

   localparam int ST_F  = 7;
   localparam int ST_5S = 6;
   localparam int ST_C  = 5;

   localparam logic [4:0] SPRITE_NONE = 5'h1F;

endpackage

// File: rtl/vdp_port_if_if.sv
// VRAM access bundle between the port responder (master) and video block.
// req/we/addr/wdata from master; ack/rdata back from slave.
interface vdp_vram_if #(
   parameter int ADDR_W = 14
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic              ack;
   logic [7:0]        rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );

endinterface

// File: rtl/vdp_port_if_status_flags.sv
// VDP status latches F / C / 5S, fifth-sprite number and interrupt.
// Ports: clk, reset, clr (status read), event pulses, ie (R1[5]),
// status byte out, n_int out.
module vdp_status_flags
   import vdp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       frame_pulse,
   input  logic       coinc_pulse,
   input  logic       fifth_pulse,
   input  logic [4:0] fifth_num,
   input  logic       ie,
   output logic [7:0] status,
   output logic       n_int
);

   logic       f_q;
   logic       c_q;
   logic       s5_q;
   logic [4:0] num_q;

   // A set pulse in the clearing cycle wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_q   <= 1'b0;
         c_q   <= 1'b0;
         s5_q  <= 1'b0;
         num_q <= 5'd0;
      end else begin
         f_q  <= frame_pulse | (f_q & ~clr);
         c_q  <= coinc_pulse | (c_q & ~clr);
         s5_q <= fifth_pulse | (s5_q & ~clr);
         if (fifth_pulse && !s5_q)
            num_q <= fifth_num;
      end
   end

   always_comb begin
      status        = 8'h00;
      status[ST_F]  = f_q;
      status[ST_5S] = s5_q;
      status[ST_C]  = c_q;
      status[4:0]   = s5_q ? num_q : SPRITE_NONE;
   end

   assign n_int = ~(f_q & ie);

endmodule

// File: rtl/vdp_port_if.sv
// TMS9918-style VDP CPU port responder: control latch, registers,
// auto-increment VRAM address, read-ahead buffer, status, interrupt.
// Ports: clk, reset, cpu_wr/cpu_rd/cpu_port/cpu_din/cpu_dout, busy,
// vram (master), regs, event pulses, n_int.
// Optional: VDP_OVERRUN_CNT_EN adds overrun_cnt (dropped strobes).
module vdp_port_if
   import vdp_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int NUM_REGS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_wr,
   input  logic                  cpu_rd,
   input  logic                  cpu_port,
   input  logic [7:0]            cpu_din,
   output logic [7:0]            cpu_dout,
   output logic                  busy,
   vdp_vram_if.master            vram,
   output logic [8*NUM_REGS-1:0] regs,
   input  logic                  frame_pulse,
   input  logic                  coinc_pulse,
   input  logic                  fifth_pulse,
   input  logic [4:0]            fifth_num,
   output logic                  n_int
`ifdef VDP_OVERRUN_CNT_EN
   ,
   output logic [7:0]            overrun_cnt
`endif
);

   localparam int RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic [7:0]        read_buf;
   logic              latch;
   logic [7:0]        first;
   logic [7:0]        reg_q [NUM_REGS];
   logic [7:0]        status;

   logic idle;
   logic d_wr;
   logic d_rd;
   logic c_wr;
   logic c_rd;
   logic set_reg;
   logic set_addr;
   logic rd_setup;
   logic done;

   // Strobes are only honoured in IDLE; anything else is dropped.
   assign idle     = (state == IDLE);
   assign d_wr     = idle & cpu_wr & (cpu_port == DATA_PORT);
   assign d_rd     = idle & cpu_rd & ~cpu_wr
                   & (cpu_port == DATA_PORT);
   assign c_wr     = idle & cpu_wr & (cpu_port == CTRL_PORT);
   assign c_rd     = idle & cpu_rd & ~cpu_wr
                   & (cpu_port == CTRL_PORT);
   assign set_reg  = c_wr & latch & cpu_din[7];
   assign set_addr = c_wr & latch & ~cpu_din[7];
   assign rd_setup = set_addr & ~cpu_din[6];
   assign done     = ~idle & vram.ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (d_wr)
               state_nx = WR_WAIT;
            else if (d_rd || rd_setup)
               state_nx = RD_WAIT;
         end
         WR_WAIT,
         RD_WAIT: begin
            if (vram.ack)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      vram.req = (state != IDLE);
      vram.we  = (state == WR_WAIT);
   end

   assign vram.addr  = addr;
   assign vram.wdata = wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr     <= '0;
         wdata    <= 8'h00;
         read_buf <= 8'h00;
         latch    <= 1'b0;
         first    <= 8'h00;
         for (int i = 0; i < NUM_REGS; i++)
            reg_q[i] <= 8'h00;
      end else begin
         if (d_wr) begin
            wdata    <= cpu_din;
            read_buf <= cpu_din;
         end
         if (done) begin
            addr <= addr + 1'b1;
            if (state == RD_WAIT)
               read_buf <= vram.rdata;
         end else if (set_addr) begin
            addr <= ADDR_W'({cpu_din[5:0], first});
         end
         if (d_wr || d_rd || c_rd)
            latch <= 1'b0;
         else if (c_wr)
            latch <= ~latch;
         if (c_wr && !latch)
            first <= cpu_din;
         if (set_reg)
            reg_q[cpu_din[RI_W-1:0]] <= first;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      assign regs[8*i +: 8] = reg_q[i];
   end

   vdp_status_flags u_flags (
      .clk         (clk),
      .reset       (reset),
      .clr         (c_rd),
      .frame_pulse (frame_pulse),
      .coinc_pulse (coinc_pulse),
      .fifth_pulse (fifth_pulse),
      .fifth_num   (fifth_num),
      .ie          (reg_q[1][5]),
      .status      (status),
      .n_int       (n_int)
   );

   always_comb begin
      cpu_dout = (cpu_port == CTRL_PORT) ? status : read_buf;
   end

`ifdef VDP_OVERRUN_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overrun_cnt <= 8'h00;
      else if (!idle && (cpu_wr || cpu_rd) && overrun_cnt != 8'hFF)
         overrun_cnt <= overrun_cnt + 8'h01;
   end
`endif

endmodule

// File: tb/tb_vdp_port_if.sv
// Testbench for vdp_port_if: directed vector table, hand sequences for
// flags / busy / reset, then random ops against a transaction model.
module tb_vdp_port_if;
   import vdp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_wr, cpu_rd, cpu_port;
   logic [7:0]  cpu_din, cpu_dout;
   logic        busy;
   logic [63:0] regs;
   logic        frame_pulse, coinc_pulse, fifth_pulse;
   logic [4:0]  fifth_num;
   logic        n_int;
`ifdef VDP_OVERRUN_CNT_EN
   logic [7:0]  overrun_cnt;
`endif

   vdp_vram_if #(.ADDR_W(14)) vram ();

   always #5 clk = ~clk;

   vdp_port_if #(.ADDR_W(14), .NUM_REGS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_wr      (cpu_wr),
      .cpu_rd      (cpu_rd),
      .cpu_port    (cpu_port),
      .cpu_din     (cpu_din),
      .cpu_dout    (cpu_dout),
      .busy        (busy),
      .vram        (vram),
      .regs        (regs),
      .frame_pulse (frame_pulse),
      .coinc_pulse (coinc_pulse),
      .fifth_pulse (fifth_pulse),
      .fifth_num   (fifth_num),
      .n_int       (n_int)
`ifdef VDP_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   typedef struct {
      bit          we;
      logic [13:0] addr;
      logic [7:0]  data;
   } acc_t;

   typedef struct {
      bit         wr;
      bit         port;
      logic [7:0] din;
      bit         cd;
      logic [7:0] dout;
      bit         has_acc;
      acc_t       acc;
   } vec_t;

   acc_t       act_q[$];
   acc_t       exp_q[$];
   logic [7:0] mem [0:16383];
   int         ack_delay = 0;
   int         checks = 0;
   int         errors = 0;

   // model state
   int         m_addr;
   logic [7:0] m_rbuf, m_first;
   bit         m_latch;
   logic [7:0] m_regs [8];
   bit         m_f, m_c, m_5;
   logic [4:0] m_num;
   logic [7:0] mm [0:16383];

   function automatic logic [7:0] pat(int i);
      return 8'(i * 37 + 27);
   endfunction

   function automatic acc_t mk_acc(bit we, int a, logic [7:0] d);
      acc_t r;
      r.we = we; r.addr = 14'(a); r.data = d;
      return r;
   endfunction

   function automatic vec_t v(bit wr, bit port, logic [7:0] din,
                              bit cd, logic [7:0] dout,
                              bit ha, bit we, int a, logic [7:0] d);
      vec_t r;
      r.wr = wr; r.port = port; r.din = din;
      r.cd = cd; r.dout = dout; r.has_acc = ha;
      r.acc = mk_acc(we, a, d);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_acc(input string nm);
      acc_t a, e;
      chk({nm, " acc count"}, 64'(act_q.size()), 64'(exp_q.size()));
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front();
         e = exp_q.pop_front();
         chk({nm, " acc"}, {a.we, a.addr, a.data}, {e.we, e.addr, e.data});
      end
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: busy got 1 expected 0", nm);
      end
   endtask

   task automatic do_op(input bit wr, input bit port,
                        input logic [7:0] din, output logic [7:0] dout);
      @(negedge clk);
      cpu_wr = wr; cpu_rd = !wr; cpu_port = port; cpu_din = din;
      #1 dout = cpu_dout;
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      wait_idle("op");
   endtask

   task automatic pulse(input bit f, input bit c, input bit s,
                        input logic [4:0] n);
      @(negedge clk);
      frame_pulse = f; coinc_pulse = c; fifth_pulse = s; fifth_num = n;
      @(negedge clk);
      frame_pulse = 0; coinc_pulse = 0; fifth_pulse = 0;
   endtask

   function automatic logic [7:0] m_status();
      return {m_f, m_5, m_c, m_5 ? m_num : 5'h1F};
   endfunction

   function automatic logic [63:0] m_regflat();
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
      return r;
   endfunction

   function automatic void m_prefetch();
      exp_q.push_back(mk_acc(0, m_addr, mm[m_addr]));
      m_rbuf = mm[m_addr];
      m_addr = (m_addr + 1) % 16384;
   endfunction

   // VRAM model: acks after ack_delay extra cycles
   initial begin
      int   cnt;
      acc_t a;
      cnt = -1;
      vram.ack = 1'b0;
      vram.rdata = 8'h00;
      forever begin
         @(negedge clk);
         vram.ack = 1'b0;
         if (reset || !vram.req) begin
            cnt = -1;
         end else begin
            if (cnt < 0) cnt = ack_delay;
            if (cnt == 0) begin
               a.we = vram.we;
               a.addr = vram.addr;
               if (vram.we) begin
                  mem[vram.addr] = vram.wdata;
                  a.data = vram.wdata;
               end else begin
                  vram.rdata = mem[vram.addr];
                  a.data = vram.rdata;
               end
               act_q.push_back(a);
               vram.ack = 1'b1;
               cnt = -1;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin
      vec_t       vt[$];
      logic [7:0] d, dout, e;
      int         r;
      bit         pf, pc, ps;

      reset = 1'b1;
      cpu_wr = 0; cpu_rd = 0; cpu_port = 0; cpu_din = 0;
      frame_pulse = 0; coinc_pulse = 0; fifth_pulse = 0; fifth_num = 0;
      for (int i = 0; i < 16384; i++) mem[i] = pat(i);
      mem[16383] = 8'h12;

      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst req", vram.req, 0);
      chk("rst n_int", n_int, 1);
      chk("rst regs", regs, 0);
      cpu_port = 1; #1;
      chk("rst status", cpu_dout, 8'h1F);
      cpu_port = 0; #1;
      chk("rst read_buf", cpu_dout, 8'h00);
      reset = 1'b0;

      // directed vector table
      vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(1, 1, 8'h40, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(1, 0, 8'hAA, 0, 0, 1, 1, 0, 8'hAA));
      vt.push_back(v(1, 0, 8'h55, 0, 0, 1, 1, 1, 8'h55));
      vt.push_back(v(0, 0, 8'h00, 1, 8'h55, 1, 0, 2, pat(2)));
      vt.push_back(v(1, 1, 8'hE2, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(1, 1, 8'h81, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(1, 1, 8'hFF, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(1, 1, 8'h3F, 0, 0, 1, 0, 16383, 8'h12));
      vt.push_back(v(0, 0, 8'h00, 1, 8'h12, 1, 0, 0, 8'hAA));
      vt.push_back(v(1, 1, 8'h34, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 1, 8'h00, 1, 8'h1F, 0, 0, 0, 0));
      vt.push_back(v(1, 1, 8'h00, 0, 0, 0, 0, 0, 0));
      vt.push_back(v(0, 0, 8'h00, 1, 8'hAA, 1, 0, 1, 8'h55));

      foreach (vt[i]) begin
         if (vt[i].has_acc) exp_q.push_back(vt[i].acc);
         do_op(vt[i].wr, vt[i].port, vt[i].din, dout);
         if (vt[i].cd) chk($sformatf("vec%0d dout", i), dout, vt[i].dout);
         chk_acc($sformatf("vec%0d", i));
      end
      chk("regs after table", regs, 64'h0000_0000_0000_E200);

      // interrupt and status clear-on-read
      chk("n_int idle", n_int, 1);
      pulse(1, 0, 0, 0);
      chk("n_int frame", n_int, 0);
      do_op(0, 1, 0, dout);
      chk("status F", dout, 8'h9F);
      chk("n_int cleared", n_int, 1);

      pulse(1, 0, 1, 5'd7);
      do_op(0, 1, 0, dout);
      chk("status F5S", dout, 8'hC7);
      do_op(0, 1, 0, dout);
      chk("status after clr", dout, 8'h1F);

      pulse(0, 0, 1, 5'd3);
      pulse(0, 0, 1, 5'd9);
      do_op(0, 1, 0, dout);
      chk("fifth num held", dout, 8'h43);

      // coinc in the clearing cycle survives
      @(negedge clk);
      cpu_rd = 1; cpu_port = 1; coinc_pulse = 1;
      #1 dout = cpu_dout;
      @(negedge clk);
      cpu_rd = 0; coinc_pulse = 0;
      chk("status pre coinc", dout, 8'h1F);
      do_op(0, 1, 0, dout);
      chk("coinc set wins", dout, 8'h3F);
      do_op(0, 1, 0, dout);
      chk("coinc cleared", dout, 8'h1F);

      // slow ack with a strobe dropped while busy
      ack_delay = 5;
      @(negedge clk);
      cpu_wr = 1; cpu_port = 0; cpu_din = 8'h77;
      @(negedge clk);
      cpu_wr = 0;
      chk("busy after strobe", busy, 1);
      chk("req after strobe", vram.req, 1);
      @(negedge clk);
      cpu_wr = 1; cpu_din = 8'h99;
      @(negedge clk);
      cpu_wr = 0;
      wait_idle("slow write");
      exp_q.push_back(mk_acc(1, 2, 8'h77));
      chk_acc("slow write");
`ifdef VDP_OVERRUN_CNT_EN
      chk("overrun", overrun_cnt, 1);
`endif
      ack_delay = 0;
      exp_q.push_back(mk_acc(0, 3, pat(3)));
      do_op(0, 0, 0, dout);
      chk("dropped strobe ignored", dout, 8'h77);
      chk_acc("after drop");

      // reset in the middle of a pending access
      ack_delay = 5;
      @(negedge clk);
      cpu_wr = 1; cpu_port = 0; cpu_din = 8'h66;
      @(negedge clk);
      cpu_wr = 0;
      @(negedge clk);
      reset = 1;
      #1;
      chk("req drop on reset", vram.req, 0);
      chk("busy drop on reset", busy, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      chk("regs after reset", regs, 0);
      chk("n_int after reset", n_int, 1);
      cpu_port = 0; #1;
      chk("read_buf after reset", cpu_dout, 8'h00);
`ifdef VDP_OVERRUN_CNT_EN
      chk("overrun after reset", overrun_cnt, 0);
`endif
      ack_delay = 0;
      act_q.delete();
      exp_q.push_back(mk_acc(0, 0, 8'hAA));
      do_op(0, 0, 0, dout);
      chk("read after reset", dout, 8'h00);
      chk_acc("after reset");

      // random ops against the transaction model
      mm = mem;
      m_addr = 1; m_rbuf = 8'hAA; m_first = 0; m_latch = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_f = 0; m_c = 0; m_5 = 0; m_num = 0;

      for (int n = 0; n < 400; n++) begin
         ack_delay = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         if (r < 2) begin
            exp_q.push_back(mk_acc(1, m_addr, d));
            mm[m_addr] = d;
            m_rbuf = d;
            m_addr = (m_addr + 1) % 16384;
            m_latch = 0;
            do_op(1, 0, d, dout);
         end else if (r < 4) begin
            e = m_rbuf;
            m_prefetch();
            m_latch = 0;
            do_op(0, 0, 0, dout);
            chk("rand data read", dout, e);
         end else if (r < 7) begin
            if (!m_latch) begin
               m_first = d;
               m_latch = 1;
            end else begin
               m_latch = 0;
               if (d[7]) begin
                  m_regs[d % 8] = m_first;
               end else begin
                  m_addr = (d % 64) * 256 + m_first;
                  if (!d[6]) m_prefetch();
               end
            end
            do_op(1, 1, d, dout);
         end else if (r < 8) begin
            e = m_status();
            m_f = 0; m_c = 0; m_5 = 0;
            m_latch = 0;
            do_op(0, 1, 0, dout);
            chk("rand status", dout, e);
         end else begin
            pf = 1'($urandom); pc = 1'($urandom); ps = 1'($urandom);
            pulse(pf, pc, ps, d[4:0]);
            if (ps && !m_5) m_num = d[4:0];
            m_f |= pf; m_c |= pc; m_5 |= ps;
         end
         chk_acc("rand");
         chk("rand regs", regs, m_regflat());
         chk("rand n_int", n_int, !(m_f && m_regs[1][5]));
      end
`ifdef VDP_OVERRUN_CNT_EN
      chk("overrun end", overrun_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/vdp_port_if.md
Name: vdp_port_if

Overview:
CPU-facing responder for the TMS9918-style VDP I/O ports (data 0xBE, ctrl 0xBF). It owns:
- the two-byte control latch and the eight VDP registers;
- the 14-bit auto-incrementing VRAM address and the read-ahead buffer;
- status flags with clear-on-read;
- the interrupt output.

It converts single-cycle CPU port strobes into a req/ack VRAM access for the video block. The top-level port decode supplies the strobes already qualified by the CPU clock-enable edge.

Parameters:
ADDR_W, 14, VRAM address width; the address wraps modulo 2^ADDR_W.
NUM_REGS, 8, number of VDP registers; the register index is taken from the low log2(NUM_REGS) bits.

Ports:
clk  in  1  system clock (cpuClock domain)
reset  in  1  asynchronous, active-high reset
cpu_wr  in  1  one-cycle CPU write strobe
cpu_rd  in  1  one-cycle CPU read strobe
cpu_port  in  1  0 = data port, 1 = control port
cpu_din  in  8  CPU write data
cpu_dout  out  8  combinational: read_buf when cpu_port=0, status when cpu_port=1
busy  out  1  high while a VRAM access is pending; top drives CPU wait_n from it
vram_req  out  1  request, held until vram_ack
vram_we  out  1  access type, valid with vram_req
vram_addr  out  ADDR_W  access address, valid with vram_req
vram_wdata  out  8  write data, valid with vram_req
vram_ack  in  1  one-cycle completion; for reads, vram_rdata is valid in the same cycle
vram_rdata  in  8  read data
regs  out  8*NUM_REGS  flattened register file; R0 in bits [7:0]
frame_pulse  in  1  end-of-active-frame event, sets F
coinc_pulse  in  1  sprite collision event, sets C
fifth_pulse  in  1  fifth-sprite event, sets 5S
fifth_num  in  5  sprite number accompanying fifth_pulse
n_int  out  1  active-low interrupt = ~(F & R1[5])

Behaviour:
Reset values:
- all regs = 0, addr = 0, read_buf = 0, latch flag = 0, first byte = 0;
- F = C = 5S = 0, sprite number = 0;
- vram_req = 0, busy = 0, n_int = 1, state = IDLE.

FSM states: IDLE, WR_WAIT, RD_WAIT.
- IDLE → WR_WAIT on a data write. Issue req with we=1, addr, wdata=cpu_din. Also set read_buf = cpu_din.
- IDLE → RD_WAIT on a data read. Issue req with we=0 at the current addr (prefetch). cpu_dout during the strobe cycle is the old read_buf.
- IDLE → RD_WAIT on a control second byte with cpu_din[7:6] = 2'b00 (read setup).
- WR_WAIT → IDLE on ack; addr increments.
- RD_WAIT → IDLE on ack; read_buf = vram_rdata, addr increments.
- busy = (state != IDLE). It goes high the cycle after the strobe, and vram_req asserts that same cycle.
- A strobe arriving while busy is dropped; no state change. The CPU is required to honour busy.
- vram_req deasserts the cycle after ack. Minimum turnaround is 2 clocks.

Control port write:
- Latch flag = 0: store cpu_din as the first byte; flag = 1.
- Latch flag = 1: flag = 0.
  - cpu_din[7] = 1: regs[cpu_din[2:0]] = first byte.
  - cpu_din[7] = 0: addr = {cpu_din[5:0], first byte}. Bit 6 = 1 means write setup (no access); bit 6 = 0 means read setup (prefetch).

Latch flag clearing:
- Any data-port access, or a control-port read, clears the latch flag.

Status and flags:
- status = {F, 5S, C, 5S ? sprite_num : 5'h1F}.
- A control-port read clears F, C and 5S on the next clock.
- If a set pulse coincides with the clearing cycle, set wins.
- fifth_pulse latches fifth_num only while 5S = 0.

Address arithmetic:
- Address increment wraps 0x3FFF → 0x0000.

Reset mid-access:
- reset drops vram_req immediately. A late ack after reset is ignored.

Optional Feature:
Macro VDP_OVERRUN_CNT_EN.
- Defined: adds output overrun_cnt [7:0], reset 0. It counts strobes dropped while busy and saturates at 0xFF.
- Undefined: the port is absent; drops are silent.

Decomposition:
Package vdp_pkg holds:
- DATA_PORT and CTRL_PORT constants;
- the state enum (IDLE, WR_WAIT, RD_WAIT);
- status bit positions (F = 7, 5S = 6, C = 5);
- SPRITE_NONE = 5'h1F.

Sub-module vdp_status_flags holds the F/C/5S latches, sprite number capture, set-wins-over-clear logic and n_int.

Test Plan:
1. Ctrl writes 0x00, 0x40, then data writes 0xAA, 0x55 → two VRAM writes, at 0x0000 = 0xAA and 0x0001 = 0x55; final addr = 0x0002.
2. Ctrl writes 0xE2, 0x81 → regs R1 = 0xE2; no vram_req; n_int = 0 after frame_pulse.
3. Ctrl writes 0xFF, 0x3F, model returns 0x12 → prefetch read at 0x3FFF, read_buf = 0x12, addr wraps to 0x0000; then data read → cpu_dout = 0x12 and prefetch at 0x0000.
4. frame_pulse and fifth_pulse with num = 7, then status read → cpu_dout = 0xC7; next status read = 0x1F. A coinc_pulse in the clearing cycle leaves C = 1.
5. Ctrl write 0x34, then status read, then ctrl write 0x00 → the second write is treated as a first byte; no register or address change.
6. Data write with ack delayed 5 cycles, plus an extra strobe while busy → the strobe is dropped (overrun_cnt = 1 with VDP_OVERRUN_CNT_EN). Reset asserted mid-wait → vram_req = 0 immediately.
